// File: rtl/cla_mp_add_seq_if.sv
// Handshake bundle for the multi-precision add sequencer: command, operand stream and result stream.
// With CLA_MP_SUB_EN defined the command also carries cmd_sub.
interface cla_mp_add_seq_if #(
    parameter int LEN_W = 4
) ();
    logic             cmd_valid;
    logic             cmd_ready;
    logic [LEN_W-1:0] cmd_len;
    logic             cmd_cin;
`ifdef CLA_MP_SUB_EN
    logic             cmd_sub;
`endif
    logic             in_valid;
    logic             in_ready;
    logic [15:0]      in_a;
    logic [15:0]      in_b;
    logic             out_valid;
    logic             out_ready;
    logic [15:0]      out_sum;
    logic             out_last;
    logic             out_cout;
    logic             busy;
    logic             err_len;

    modport master (
`ifdef CLA_MP_SUB_EN
        output cmd_sub,
`endif
        output cmd_valid, cmd_len, cmd_cin, in_valid, in_a, in_b, out_ready,
        input  cmd_ready, in_ready, out_valid, out_sum, out_last, out_cout, busy, err_len
    );

    modport slave (
`ifdef CLA_MP_SUB_EN
        input  cmd_sub,
`endif
        input  cmd_valid, cmd_len, cmd_cin, in_valid, in_a, in_b, out_ready,
        output cmd_ready, in_ready, out_valid, out_sum, out_last, out_cout, busy, err_len
    );
endinterface

// File: rtl/cla_mp_add_seq.sv
// Multi-precision add sequencer: streams 16-bit word pairs LSW first through one 16-bit CLA,
// carrying between words in a register. Define CLA_MP_SUB_EN to add the cmd_sub subtract mode.
module CLA_Adder_16bit (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    output logic [15:0] s,
    output logic        cout
);
    // Returns carries c[4:0] of a 4-wide lookahead block, c[0] being the block carry-in.
    function automatic logic [4:0] cla4(input logic [3:0] g, input logic [3:0] p, input logic c0);
        logic [4:0] c;
        c[0] = c0;
        c[1] = g[0] | (p[0] & c0);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & c0);
        return c;
    endfunction

    logic [15:0] g, p, c;
    logic [3:0]  gg, gp;
    logic [4:0]  cb;
    logic [4:0]  cblk;

    always_comb begin
        g    = a & b;
        p    = a ^ b;
        gg   = '0;
        gp   = '0;
        c    = '0;
        cblk = '0;
        for (int k = 0; k < 4; k++) begin
            gg[k] = g[4*k+3] | (p[4*k+3] & g[4*k+2]) | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                  | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
            gp[k] = &p[4*k +: 4];
        end
        cb = cla4(gg, gp, cin);
        for (int k = 0; k < 4; k++) begin
            cblk       = cla4(g[4*k +: 4], p[4*k +: 4], cb[k]);
            c[4*k +: 4] = cblk[3:0];
        end
        s    = p ^ c;
        cout = cb[4];
    end
endmodule

module cla_mp_add_seq #(
    parameter int MAX_WORDS = 8,
    parameter int LEN_W     = 4
) (
    input  logic clk,
    input  logic rst,
    cla_mp_add_seq_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_WORDS);
    localparam logic [LEN_W-1:0] ONE     = LEN_W'(1);

    state_t           state;
    logic             carry_reg;
    logic [LEN_W-1:0] word_cnt;
    logic [LEN_W-1:0] len_reg;
    logic [15:0]      b_p0;
    logic [15:0]      sum_p0;
    logic             cout_p0;
    logic             in_fire;
    logic             out_fire;
    logic             last_word;
    logic             len_bad;

`ifdef CLA_MP_SUB_EN
    logic             sub_reg;
    assign b_p0 = sub_reg ? ~bus.in_b : bus.in_b;
`else
    assign b_p0 = bus.in_b;
`endif

    CLA_Adder_16bit u_add (
        .a    (bus.in_a),
        .b    (b_p0),
        .cin  (carry_reg),
        .s    (sum_p0),
        .cout (cout_p0)
    );

    assign bus.cmd_ready = (state == IDLE);
    assign bus.busy      = (state != IDLE);
    assign bus.in_ready  = (state == RUN) && (!bus.out_valid || bus.out_ready);
    assign in_fire       = bus.in_valid && bus.in_ready;
    assign out_fire      = bus.out_valid && bus.out_ready;
    assign last_word     = (word_cnt == len_reg - ONE);
    assign len_bad       = (bus.cmd_len == '0) || (bus.cmd_len > MAX_LEN);

    // Adder stage -> output register; carry_reg is the only path between words.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            carry_reg     <= 1'b0;
            word_cnt      <= '0;
            len_reg       <= '0;
            bus.out_valid <= 1'b0;
            bus.out_sum   <= '0;
            bus.out_last  <= 1'b0;
            bus.out_cout  <= 1'b0;
            bus.err_len   <= 1'b0;
`ifdef CLA_MP_SUB_EN
            sub_reg       <= 1'b0;
`endif
        end else begin
            bus.err_len <= 1'b0;
            if (out_fire) begin
                bus.out_valid <= 1'b0;
                bus.out_last  <= 1'b0;
                bus.out_cout  <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (bus.cmd_valid) begin
                        if (len_bad) begin
                            bus.err_len <= 1'b1;
                        end else begin
                            len_reg  <= bus.cmd_len;
                            word_cnt <= '0;
                            state    <= RUN;
`ifdef CLA_MP_SUB_EN
                            sub_reg   <= bus.cmd_sub;
                            carry_reg <= bus.cmd_sub ? 1'b1 : bus.cmd_cin;
`else
                            carry_reg <= bus.cmd_cin;
`endif
                        end
                    end
                end
                RUN: begin
                    if (in_fire) begin
                        bus.out_sum   <= sum_p0;
                        bus.out_valid <= 1'b1;
                        carry_reg     <= cout_p0;
                        word_cnt      <= word_cnt + ONE;
                        bus.out_last  <= last_word;
                        bus.out_cout  <= last_word ? cout_p0 : 1'b0;
                        if (last_word) state <= FLUSH;
                    end
                end
                FLUSH: begin
                    if (out_fire) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cla_mp_add_seq.sv
// Directed bench for cla_mp_add_seq: table of multi-word sums plus hand-written backpressure,
// length-error and mid-operation reset sequences; subtract vectors when CLA_MP_SUB_EN is defined.
module tb_cla_mp_add_seq;
    localparam int MAX_WORDS = 8;
    localparam int LEN_W     = 4;

    typedef struct {
        int                len;
        logic              cin;
        logic              sub;
        logic [7:0][15:0]  a;
        logic [7:0][15:0]  b;
        logic [7:0][15:0]  s;
        logic              cout;
    } vec_t;

    typedef struct {
        logic [15:0] sum;
        logic        last;
        logic        cout;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;
    int   rcv_cnt = 0;
    exp_t exp_q[$];
    vec_t vecs[6];
    vec_t v;

    cla_mp_add_seq_if #(.LEN_W(LEN_W)) bus ();

    cla_mp_add_seq #(.MAX_WORDS(MAX_WORDS), .LEN_W(LEN_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Output scoreboard: a transfer happens at the next posedge when valid&&ready here.
    always @(negedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) begin
            exp_t e;
            rcv_cnt++;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_output: got sum 0x%0h, no output expected", bus.out_sum);
            end else begin
                e = exp_q.pop_front();
                check("out_sum", 32'(bus.out_sum), 32'(e.sum));
                check("out_last", 32'(bus.out_last), 32'(e.last));
                check("out_cout", 32'(bus.out_cout), 32'(e.cout));
            end
        end
    end

    task automatic send_cmd(input int len, input logic cin, input logic sub);
        bit ok = 0;
        bus.cmd_valid = 1'b1;
        bus.cmd_len   = LEN_W'(len);
        bus.cmd_cin   = cin;
`ifdef CLA_MP_SUB_EN
        bus.cmd_sub   = sub;
`endif
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (bus.cmd_ready) ok = 1;
            @(posedge clk); #1;
        end
        bus.cmd_valid = 1'b0;
        if (!ok) check("cmd_accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic send_word(input logic [15:0] a, input logic [15:0] b);
        bit ok = 0;
        bus.in_valid = 1'b1;
        bus.in_a     = a;
        bus.in_b     = b;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (bus.in_ready) ok = 1;
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        if (!ok) check("in_accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_drain();
        bit ok = 0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(posedge clk);
            if (exp_q.size() == 0) ok = 1;
        end
        if (!ok) check("drain_timeout", 32'(exp_q.size()), 32'd0);
        @(negedge clk);
        check("busy_after_consume", 32'(bus.busy), 32'd0);
        check("cmd_ready_after_consume", 32'(bus.cmd_ready), 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic run_vector(input vec_t t);
        exp_t e;
        for (int i = 0; i < t.len; i++) begin
            e.sum  = t.s[i];
            e.last = (i == t.len - 1);
            e.cout = (i == t.len - 1) ? t.cout : 1'b0;
            exp_q.push_back(e);
        end
        send_cmd(t.len, t.cin, t.sub);
        for (int i = 0; i < t.len; i++) send_word(t.a[i], t.b[i]);
        wait_drain();
    endtask

    task automatic len_error(input int len);
        send_cmd(len, 1'b0, 1'b0);
        @(negedge clk);
        check("err_len_pulse", 32'(bus.err_len), 32'd1);
        check("err_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        check("err_no_output", 32'(bus.out_valid), 32'd0);
        @(negedge clk);
        check("err_len_clear", 32'(bus.err_len), 32'd0);
        check("err_busy", 32'(bus.busy), 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        logic [15:0] held;
        int          base;
        bit          ok;

        bus.cmd_valid = 1'b0;
        bus.cmd_len   = '0;
        bus.cmd_cin   = 1'b0;
`ifdef CLA_MP_SUB_EN
        bus.cmd_sub   = 1'b0;
`endif
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.out_ready = 1'b1;

        for (int i = 0; i < 6; i++) begin
            vecs[i].len = 1; vecs[i].cin = 0; vecs[i].sub = 0; vecs[i].cout = 0;
            vecs[i].a = '0; vecs[i].b = '0; vecs[i].s = '0;
        end
        vecs[0].len = 1; vecs[0].a[0] = 16'hABF5; vecs[0].b[0] = 16'hFEF5;
        vecs[0].s[0] = 16'hAAEA; vecs[0].cout = 1;
        vecs[1].len = 2; vecs[1].a[0] = 16'hFFFF; vecs[1].b[0] = 16'h0001;
        vecs[1].s[0] = 16'h0000; vecs[1].s[1] = 16'h0001; vecs[1].cout = 0;
        vecs[2].len = 3;
        vecs[2].a[0] = 16'h1234; vecs[2].b[0] = 16'h1111; vecs[2].s[0] = 16'h2345;
        vecs[2].a[1] = 16'hFFFF; vecs[2].b[1] = 16'h0001; vecs[2].s[1] = 16'h0000;
        vecs[2].a[2] = 16'h8000; vecs[2].b[2] = 16'h8000; vecs[2].s[2] = 16'h0001;
        vecs[2].cout = 1;
        vecs[3].len = 8; vecs[3].cout = 1;
        for (int i = 0; i < 8; i++) begin
            vecs[3].a[i] = 16'h8000; vecs[3].b[i] = 16'h8000;
            vecs[3].s[i] = (i == 0) ? 16'h0000 : 16'h0001;
        end
        vecs[4].len = 1; vecs[4].cin = 1; vecs[4].a[0] = 16'hFFFF; vecs[4].b[0] = 16'hFFFF;
        vecs[4].s[0] = 16'hFFFF; vecs[4].cout = 1;
        vecs[5].len = 2; vecs[5].cin = 1;
        vecs[5].a[0] = 16'h7FFF; vecs[5].b[0] = 16'h0000; vecs[5].s[0] = 16'h8000;
        vecs[5].a[1] = 16'h0F0F; vecs[5].b[1] = 16'hF0F0; vecs[5].s[1] = 16'hFFFF;
        vecs[5].cout = 0;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_err_len", 32'(bus.err_len), 32'd0);
        check("rst_in_ready", 32'(bus.in_ready), 32'd0);
        check("rst_out_last", 32'(bus.out_last), 32'd0);
        @(posedge clk); #1;

        for (int i = 0; i < 6; i++) run_vector(vecs[i]);

        // Backpressure: stall the second result for three cycles.
        base = rcv_cnt;
        for (int i = 0; i < 4; i++) exp_q.push_back('{16'h0000, i == 3, i == 3});
        send_cmd(4, 1'b1, 1'b0);
        fork
            begin
                for (int i = 0; i < 4; i++) send_word(16'hFFFF, 16'h0000);
            end
            begin
                ok = 0;
                for (int i = 0; i < 50 && !ok; i++) begin
                    @(posedge clk);
                    if (rcv_cnt - base >= 1) ok = 1;
                end
                if (!ok) check("bp_first_timeout", 32'd0, 32'd1);
                #1 bus.out_ready = 1'b0;
                held = bus.out_sum;
                for (int i = 0; i < 3; i++) begin
                    @(negedge clk);
                    check("bp_out_valid", 32'(bus.out_valid), 32'd1);
                    check("bp_out_sum_stable", 32'(bus.out_sum), 32'(held));
                    check("bp_in_ready", 32'(bus.in_ready), 32'd0);
                    check("bp_out_last", 32'(bus.out_last), 32'd0);
                    @(posedge clk); #1;
                end
                bus.out_ready = 1'b1;
            end
        join
        wait_drain();
        check("bp_word_count", 32'(rcv_cnt - base), 32'd4);

        len_error(0);
        len_error(MAX_WORDS + 1);

        // Reset in the middle of a 3-word operation that has just produced a carry.
        bus.out_ready = 1'b0;
        send_cmd(3, 1'b0, 1'b0);
        send_word(16'hFFFF, 16'h0001);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        check("midrst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        check("midrst_busy", 32'(bus.busy), 32'd0);
        check("midrst_out_last", 32'(bus.out_last), 32'd0);
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        v = vecs[4];
        v.cin = 0; v.len = 1; v.a[0] = 16'h0001; v.b[0] = 16'h0001; v.s[0] = 16'h0002; v.cout = 0;
        run_vector(v);

`ifdef CLA_MP_SUB_EN
        v.sub = 1; v.cin = 0; v.len = 1;
        v.a[0] = 16'h0005; v.b[0] = 16'h0007; v.s[0] = 16'hFFFE; v.cout = 0;
        run_vector(v);
        v.a[0] = 16'h0007; v.b[0] = 16'h0005; v.s[0] = 16'h0002; v.cout = 1;
        run_vector(v);
        v.len = 2;
        v.a[0] = 16'h0000; v.b[0] = 16'h0001; v.s[0] = 16'hFFFF;
        v.a[1] = 16'h0001; v.b[1] = 16'h0000; v.s[1] = 16'h0000; v.cout = 1;
        run_vector(v);
`endif

        check("queue_empty_at_end", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/cla_mp_add_seq.md
Name: cla_mp_add_seq

Overview:
- Multi-precision add sequencer built on one instance of the existing 16-bit CLA adder (CLA_Adder_16bit).
- Accepts a command giving the operand length in 16-bit words, then streams operand word pairs LSW first.
- Pushes one pair per cycle through the adder and keeps the carry in a register between words.
- Used wherever 32/64/128-bit sums are needed without widening the adder datapath.

Parameters:
- MAX_WORDS, 8, maximum operand length in 16-bit words (1..2^LEN_W-1).
- LEN_W, 4, width of the cmd_len field.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous reset, active-high.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  sequencer can accept a command (high only in IDLE).
- cmd_len  in  LEN_W  operand length in words.
- cmd_cin  in  1  initial carry-in for word 0.
- in_valid  in  1  operand word pair offered.
- in_ready  out  1  sequencer accepts the word pair this cycle.
- in_a  in  16  operand A word.
- in_b  in  16  operand B word.
- out_valid  out  1  result word valid.
- out_ready  in  1  consumer accepts the result word.
- out_sum  out  16  result word.
- out_last  out  1  marks the final result word.
- out_cout  out  1  final carry-out; meaningful only with out_last.
- busy  out  1  high in any state other than IDLE.
- err_len  out  1  one-cycle pulse on a rejected command.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state=IDLE; carry_reg, word_cnt and len_reg = 0; out_valid, out_sum, out_last, out_cout, err_len, busy = 0; cmd_ready=1 from the first cycle after reset.
- States:
  - IDLE: waiting for a command.
  - RUN: accepting word pairs.
  - FLUSH: last result held, waiting to be consumed.
- IDLE, on cmd_valid&&cmd_ready:
  - If cmd_len==0 or cmd_len>MAX_WORDS: command is consumed, err_len=1 for the next cycle, stay in IDLE.
  - Otherwise: len_reg<=cmd_len, carry_reg<=cmd_cin, word_cnt<=0, go to RUN.
- RUN handshake:
  - in_ready = (state==RUN) && (!out_valid || out_ready).
  - A single-entry output register gives full throughput of 1 word/cycle under continuous out_ready.
- On each in_valid&&in_ready:
  - The adder takes A=in_a, B=in_b, Cin=carry_reg.
  - Next edge: out_sum<=S, out_valid<=1, carry_reg<=Cout, word_cnt<=word_cnt+1.
  - Latency from input handshake to out_valid is 1 cycle.
- Last word (word_cnt==len_reg-1 at acceptance):
  - out_last<=1 and out_cout<=Cout; go to FLUSH.
  - out_cout is 0 on non-last words.
- FLUSH: when out_valid&&out_ready, clear out_valid and out_last, go to IDLE. cmd_ready stays low until IDLE.
- Output hold: out_valid is cleared on out_valid&&out_ready with no new word accepted in the same cycle. While out_valid&&!out_ready, out_sum, out_last and out_cout hold stable.
- Simultaneous events:
  - Output consumed and new word accepted in the same cycle: the register reloads and out_valid stays 1.
  - A command arriving while busy is ignored (cmd_ready=0).
- Arithmetic: unsigned modulo 2^(16*len). Carry ripples across words only through carry_reg, with no combinational path from output to input.
- Reset mid-operation: the partial sequence is discarded, everything returns to reset values, and no out_last is emitted.

Optional Feature:
- Macro: CLA_MP_SUB_EN.
- Defined:
  - Adds input port cmd_sub (1 bit), latched at command accept.
  - When it is 1, B is fed to the adder as ~in_b and the initial carry_reg is forced to 1, ignoring cmd_cin.
  - out_cout then equals NOT borrow.
- Not defined: no cmd_sub port; add only.

Test Plan:
- Single word: cmd_len=1, cin=0, A=0xABF5, B=0xFEF5 -> one output, out_sum=0xAAEA, out_last=1, out_cout=1; busy returns low 1 cycle after consume.
- Two-word carry propagation: len=2, cin=0, words (A,B)=(0xFFFF,0x0001) then (0x0000,0x0000) -> 0x0000 (last=0, cout=0), then 0x0001 (last=1, cout=0).
- Backpressure: len=4, all A=0xFFFF, B=0x0000, cin=1:
  - Expect four outputs of 0x0000, final cout=1.
  - Hold out_ready low for 3 cycles on word 2; out_sum must stay stable, in_ready=0, and no word is lost or duplicated.
- Length errors: cmd_len=0 -> err_len pulse, cmd_ready stays 1, no output. cmd_len=MAX_WORDS+1 -> same behaviour.
- Reset mid-op: len=3, assert rst after word 1 is accepted -> out_valid=0 next cycle, state IDLE, cmd_ready=1. A following len=1 command with 0x0001+0x0001 gives 0x0002 with no stale carry.
- With CLA_MP_SUB_EN: len=1, sub=1, A=0x0005, B=0x0007 -> out_sum=0xFFFE, out_cout=0. Repeat with A=0x0007, B=0x0005 -> 0x0002, cout=1.
